calc_input_sequencer: RTL

- Front-end controller for the calculator ALU datapath: debounces and edge-detects the Enter/Clear push-buttons, sequences operand A, operand B and operation code from the switches into the ALU, and captures the ALU result and flags into a result register.
- Sits between the board buttons/switches and the ALU8/Binary_to_BCD/display path.
- Exports its state and LED pattern for the display decoders.

---
 rtl/calc_input_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/calc_input_sequencer.sv
// Calculator front end: debounced Enter/Clear buttons step operands and opcode
// into the ALU, then capture the ALU result and flags.
module calc_input_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DATA_WIDTH      = 8,
    parameter int OP_WIDTH        = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [DATA_WIDTH+OP_WIDTH-1:0] Switchs,
    input  logic                           Enter,
    input  logic                           Clear,
    input  logic [DATA_WIDTH-1:0]          alu_result,
    input  logic                           alu_zero,
    input  logic                           alu_overflow,
    output logic [DATA_WIDTH-1:0]          operand_a,
    output logic [DATA_WIDTH-1:0]          operand_b,
    output logic [OP_WIDTH-1:0]            operation,
    output logic [DATA_WIDTH-1:0]          result_reg,
    output logic                           result_zero,
    output logic                           result_ovf,
    output logic                           result_valid,
    output logic [2:0]                     state,
    output logic [3:0]                     Leds
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WITH_A = 3'd1;
    localparam logic [2:0] WITH_B = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] RESULT = 3'd4;

    logic [1:0]         btn_raw;
    logic [1:0]         sync1;
    logic [1:0]         sync2;
    logic [1:0]         deb;
    logic [1:0]         deb_q;
    logic [1:0][CW-1:0] cnt;
    logic               enter_p;
    logic               clear_p;

    logic [2:0] cur;
    logic [2:0] nxt;
    logic [3:0] leds_nxt;

    assign btn_raw = {Clear, Enter};

    // bit 0 = Enter, bit 1 = Clear; any bounce restarts the stability count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        deb[i] <= sync2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign enter_p = deb[0] & ~deb_q[0];
    assign clear_p = deb[1] & ~deb_q[1];
    assign state   = cur;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cur <= IDLE;
        else       cur <= nxt;
    end

    always_comb begin
        nxt = IDLE;
        if (!clear_p) begin
            case (cur)
                IDLE:    nxt = enter_p ? WITH_A : IDLE;
                WITH_A:  nxt = enter_p ? WITH_B : WITH_A;
                WITH_B:  nxt = enter_p ? EXEC : WITH_B;
                EXEC:    nxt = RESULT;
                RESULT:  nxt = (enter_p && !result_ovf) ? WITH_A : RESULT;
                default: nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        leds_nxt = 4'b1111;
        case (nxt)
            IDLE:    leds_nxt = 4'b0001;
            WITH_A:  leds_nxt = 4'b0011;
            WITH_B:  leds_nxt = 4'b0111;
            default: leds_nxt = 4'b1111;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            operand_a    <= '0;
            operand_b    <= '0;
            operation    <= '0;
            result_reg   <= '0;
            result_zero  <= 1'b0;
            result_ovf   <= 1'b0;
            result_valid <= 1'b0;
            Leds         <= 4'b0001;
        end else begin
            Leds         <= leds_nxt;
            result_valid <= (nxt == RESULT);
            if (clear_p || cur > RESULT) begin
                operand_a   <= '0;
                operand_b   <= '0;
                operation   <= '0;
                result_reg  <= '0;
                result_zero <= 1'b0;
                result_ovf  <= 1'b0;
            end else begin
                case (cur)
                    IDLE:
                        if (enter_p) operand_a <= Switchs[DATA_WIDTH-1:0];
                    WITH_A:
                        if (enter_p) operand_b <= Switchs[DATA_WIDTH-1:0];
                    WITH_B:
                        if (enter_p)
                            operation <= Switchs[DATA_WIDTH+OP_WIDTH-1:DATA_WIDTH];
                    EXEC: begin
                        result_reg  <= alu_result;
                        result_zero <= alu_zero;
                        result_ovf  <= alu_overflow;
                    end
                    RESULT:
                        // chain the previous result in as the next operand A
                        if (enter_p && !result_ovf) begin
                            operand_a <= result_reg;
                            operand_b <= '0;
                            operation <= '0;
                        end
                    default: ;
                endcase
            end
        end
    end

endmodule
